pe2d_operand_feeder: RTL and testbench
======================================

// Module: pe2d_operand_feeder
// PURPOSE
//  Source end of the PE_2D row-stream interface: drives i_r1/i_r2/en of one 2x2 PE_2D.
//  Buffers a burst of operand row-pairs from an upstream valid/ready source.
//  Replays the burst on consecutive cycles with no bubbles, then flushes zero rows so the
//  PE drains, then drops en and pulses done. Sits between the operand SRAM reader and PE_2D.
// PARAMETERS
//  DATA_W    conv4_width  element width; each row word is 2*DATA_W (two packed elements)
//  DEPTH     16           max row-pairs per burst (FIFO entries), power of 2, >=2
//  FLUSH_CYC 2            zero-row cycles with en=1 after the last data word, >=1
// PORTS
//  clk      in   1         clock, all state on rising edge
//  rst      in   1         asynchronous, active-high reset
//  s_valid  in   1         upstream word valid
//  s_ready  out  1         feeder accepts a word this cycle
//  s_r1     in   2*DATA_W  row-1 operand word
//  s_r2     in   2*DATA_W  row-2 operand word
//  s_last   in   1         final word of the burst (qualified by s_valid&s_ready)
//  o_en     out  1         to PE_2D en
//  o_r1     out  2*DATA_W  to PE_2D i_r1
//  o_r2     out  2*DATA_W  to PE_2D i_r2
//  o_busy   out  1         high in STREAM/FLUSH/DONE
//  o_done   out  1         one-cycle pulse when en drops after flush
//  o_err    out  1         sticky: burst truncated at DEPTH words; cleared only by rst
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO empty, state FILL, all outputs 0.
//    s_ready forced 0 while rst is high.
//  - o_en, o_r1, o_r2, o_done, o_err are registered.
//    s_ready = (state==FILL) & ~full & ~rst, combinational.
//  - FILL: each s_valid&s_ready stores {s_r1,s_r2} at wr_ptr.
//    o_en=0, o_r1=o_r2=0.
//    Accepted word with s_last=1 -> STREAM; s_valid gaps allowed.
//  - Overflow: DEPTH-th word accepted with s_last=0 -> treated as last.
//    o_err<=1, -> STREAM. The upstream word after it waits for the next FILL.
//  - STREAM: if last handshake at edge N with burst length L, o_en=1 from edge N+1.
//    o_r1/o_r2 = word k at edge N+1+k, k=0..L-1, in acceptance order.
//  - FLUSH: edges N+L+1 .. N+L+FLUSH_CYC have o_en=1, o_r1=o_r2=0.
//  - DONE: edge N+L+FLUSH_CYC+1 gives o_en=0, o_done=1, rows 0.
//    Next edge: o_done=0, state FILL, FIFO pointers cleared, s_ready=1 again.
//  - L=1 is legal: one data cycle, then the flush.
//  - No input is accepted from the last handshake until DONE completes.
//    Bursts never overlap.
//  - Counters: rd_ptr/wr_ptr log2(DEPTH) bits with wrap; count log2(DEPTH)+1 bits.
//    flush counter sized for FLUSH_CYC.
//  - Pure data movement: widths preserved, no arithmetic on operands.
//  - rst mid-burst: immediate return to the reset state.
//    o_en drops asynchronously, partial burst discarded, o_err cleared.
// TESTING
//  1 Reset: hold rst 3 cycles, release -> o_en=0, o_r1=o_r2=0, o_done=0, o_err=0; s_ready=1 after release.
//  2 Burst L=4: r1=1,2,3,4 / r2=3,4,5,6, last on 4th word -> o_en=1 for 4+FLUSH_CYC cycles.
//    Rows 1/3,2/4,3/5,4/6 then 2 zero cycles, then o_en=0 with o_done=1 one cycle.
//  3 L=1: r1=7,r2=9,last -> one data cycle 7/9, 2 zero cycles, done.
//    s_ready returns 1 cycle after done.
//  4 Fill with s_valid gaps (valid 1,0,0,1,1 pattern, L=3) -> output stream contiguous, no zero bubbles between data words.
//  5 Overflow DEPTH=16: 17 words, no last -> first 16 streamed.
//    o_err=1 and sticky; s_ready=0 during stream; word 17 accepted in next FILL.
//  6 rst asserted during the 2nd data cycle of an L=4 burst -> o_en=0 immediately, rows 0.
//    After release a fresh L=2 burst streams correctly.

Source files
------------

// File: rtl/pe2d_operand_feeder.sv
// Purpose: buffers one burst of operand row-pairs, replays it bubble-free into a PE_2D, flushes zero rows, pulses done.
// Latency: first row reaches o_r1/o_r2 one edge after the last-word handshake; the burst follows on consecutive edges.
// Backpressure: s_ready is high only while filling and not full; no word is accepted from the last handshake until done completes.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-high reset
//   s_valid/s_ready          upstream word handshake; s_r1/s_r2 row words, s_last ends the burst
//   o_en, o_r1, o_r2         registered drive into PE_2D en / i_r1 / i_r2
//   o_busy                   high while streaming, flushing or signalling done
//   o_done                   one-cycle pulse as en drops after the flush
//   o_err                    sticky: a burst was cut at DEPTH words; cleared only by rst
module pe2d_operand_feeder #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int FLUSH_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [2*DATA_W-1:0] s_r1,
    input  logic [2*DATA_W-1:0] s_r2,
    input  logic                s_last,
    output logic                o_en,
    output logic [2*DATA_W-1:0] o_r1,
    output logic [2*DATA_W-1:0] o_r2,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);
    localparam int RW = 2 * DATA_W;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH, DONE} state_t;

    state_t          state;
    logic [2*RW-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [FW-1:0]   fcnt;
    logic            full;
    logic            accept;

    assign full    = (count == (AW+1)'(DEPTH));
    assign s_ready = (state == FILL) & ~full & ~rst;
    assign accept  = s_valid & s_ready;
    assign o_busy  = (state != FILL);

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= {s_r1, s_r2};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fcnt   <= '0;
            o_en   <= 1'b0;
            o_r1   <= '0;
            o_r2   <= '0;
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    o_en   <= 1'b0;
                    o_r1   <= '0;
                    o_r2   <= '0;
                    o_done <= 1'b0;
                    if (accept) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        count  <= count + 1'b1;
                        // The DEPTH-th word closes the burst even without s_last.
                        if (s_last || (count == (AW+1)'(DEPTH - 1))) begin
                            state <= STREAM;
                            if (!s_last) begin
                                o_err <= 1'b1;
                            end
                        end
                    end
                end
                STREAM: begin
                    o_en           <= 1'b1;
                    {o_r1, o_r2}   <= mem[rd_ptr];
                    rd_ptr         <= rd_ptr + 1'b1;
                    count          <= count - 1'b1;
                    if (count == (AW+1)'(1)) begin
                        state <= FLUSH;
                        fcnt  <= '0;
                    end
                end
                FLUSH: begin
                    o_r1 <= '0;
                    o_r2 <= '0;
                    // FLUSH_CYC zero rows with en high, then the edge that drops en.
                    if (fcnt == FW'(FLUSH_CYC)) begin
                        o_en   <= 1'b0;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end else begin
                        o_en <= 1'b1;
                        fcnt <= fcnt + 1'b1;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    state  <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_pe2d_operand_feeder.sv
// Purpose: directed self-checking bench for pe2d_operand_feeder (DATA_W=8, DEPTH=16, FLUSH_CYC=2).
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: stimulus only presents words while the feeder is filling, except where s_ready=0 is under test.
module tb_pe2d_operand_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_r1 = '0;
    logic [15:0] s_r2 = '0;
    logic        s_last = 1'b0;
    logic        o_en;
    logic [15:0] o_r1;
    logic [15:0] o_r2;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int tests = 0;
    int fails = 0;

    pe2d_operand_feeder #(.DATA_W(8), .DEPTH(16), .FLUSH_CYC(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_r1(s_r1), .s_r2(s_r2), .s_last(s_last),
        .o_en(o_en), .o_r1(o_r1), .o_r2(o_r2),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // Present one word for one edge; the caller ensures the feeder is filling.
    task automatic put(input logic [15:0] a, input logic [15:0] b, input logic last);
        s_valid = 1'b1; s_r1 = a; s_r2 = b; s_last = last;
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_low: got %b want 0", s_ready); end
        rst = 1'b0;
        #1;
        tests++; if ({o_en, o_r1, o_r2, o_done, o_err, o_busy} !== 35'd0) begin fails++;
            $display("FAIL rst_outputs: en=%b r1=%h r2=%h done=%b err=%b busy=%b want all 0", o_en, o_r1, o_r2, o_done, o_err, o_busy); end
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after: got %b want 1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_burst4();
        put(16'd1, 16'd3, 1'b0);
        put(16'd2, 16'd4, 1'b0);
        put(16'd3, 16'd5, 1'b0);
        put(16'd4, 16'd6, 1'b1);
        tests++; if ({s_ready, o_busy, o_en} !== 3'b010) begin fails++;
            $display("FAIL b4_after_last: ready/busy/en=%b want 010", {s_ready, o_busy, o_en}); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 16'(k + 1), 16'(k + 3)}) begin fails++;
                $display("FAIL b4_data%0d: en=%b r1=%0d r2=%0d want 1 %0d %0d", k, o_en, o_r1, o_r2, k + 1, k + 3); end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2, o_done} !== {1'b1, 32'd0, 1'b0}) begin fails++;
                $display("FAIL b4_flush%0d: en=%b r1=%0d r2=%0d done=%b want 1 0 0 0", k, o_en, o_r1, o_r2, o_done); end
        end
        @(posedge clk); #1;
        tests++; if ({o_en, o_done, o_busy, s_ready} !== 4'b0110) begin fails++;
            $display("FAIL b4_done: en/done/busy/ready=%b want 0110", {o_en, o_done, o_busy, s_ready}); end
        @(posedge clk); #1;
        tests++; if ({o_en, o_done, o_busy, s_ready} !== 4'b0001) begin fails++;
            $display("FAIL b4_idle: en/done/busy/ready=%b want 0001", {o_en, o_done, o_busy, s_ready}); end
    endtask

    task automatic test_single();
        put(16'd7, 16'd9, 1'b1);
        @(posedge clk); #1;
        tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 16'd7, 16'd9}) begin fails++;
            $display("FAIL l1_data: en=%b r1=%0d r2=%0d want 1 7 9", o_en, o_r1, o_r2); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 32'd0}) begin fails++;
                $display("FAIL l1_flush%0d: en=%b r1=%0d r2=%0d want 1 0 0", k, o_en, o_r1, o_r2); end
        end
        @(posedge clk); #1;
        tests++; if ({o_en, o_done, s_ready} !== 3'b010) begin fails++;
            $display("FAIL l1_done: en/done/ready=%b want 010", {o_en, o_done, s_ready}); end
        @(posedge clk); #1;
        tests++; if ({o_done, s_ready} !== 2'b01) begin fails++;
            $display("FAIL l1_ready_back: done/ready=%b want 01", {o_done, s_ready}); end
    endtask

    task automatic test_gaps();
        logic pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int w = 0;
        for (int i = 0; i < 5; i++) begin
            if (pat[i]) begin
                s_valid = 1'b1; s_r1 = 16'(10 + w); s_r2 = 16'(20 + w); s_last = (w == 2); w++;
            end else begin
                s_valid = 1'b0; s_last = 1'b0;
            end
            @(posedge clk); #1;
            if (i < 4) begin
                tests++; if (o_en !== 1'b0) begin fails++; $display("FAIL gap_fill_en%0d: got %b want 0", i, o_en); end
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 16'(10 + k), 16'(20 + k)}) begin fails++;
                $display("FAIL gap_data%0d: en=%b r1=%0d r2=%0d want 1 %0d %0d", k, o_en, o_r1, o_r2, 10 + k, 20 + k); end
        end
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        tests++; if ({o_en, o_done} !== 2'b01) begin fails++; $display("FAIL gap_done: en/done=%b want 01", {o_en, o_done}); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_r1 = 16'(100 + i); s_r2 = 16'(200 + i); s_last = 1'b0;
            @(posedge clk); #1;
        end
        // Word 17 stays presented and must wait out the whole stream.
        s_r1 = 16'd116; s_r2 = 16'd216;
        tests++; if ({s_ready, o_err} !== 2'b01) begin fails++;
            $display("FAIL ovf_trunc: ready/err=%b want 01", {s_ready, o_err}); end
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2, s_ready} !== {1'b1, 16'(100 + k), 16'(200 + k), 1'b0}) begin fails++;
                $display("FAIL ovf_data%0d: en=%b r1=%0d r2=%0d ready=%b want 1 %0d %0d 0", k, o_en, o_r1, o_r2, s_ready, 100 + k, 200 + k); end
        end
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        tests++; if ({o_done, s_ready, o_err} !== 3'b101) begin fails++;
            $display("FAIL ovf_done: done/ready/err=%b want 101", {o_done, s_ready, o_err}); end
        s_last = 1'b1;
        @(posedge clk); #1;
        tests++; if (s_ready !== 1'b1) begin fails++; $display("FAIL ovf_refill_ready: got %b want 1", s_ready); end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        @(posedge clk); #1;
        tests++; if ({o_en, o_r1, o_r2, o_err} !== {1'b1, 16'd116, 16'd216, 1'b1}) begin fails++;
            $display("FAIL ovf_word17: en=%b r1=%0d r2=%0d err=%b want 1 116 216 1", o_en, o_r1, o_r2, o_err); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_rst_mid();
        put(16'd21, 16'd31, 1'b0);
        put(16'd22, 16'd32, 1'b0);
        put(16'd23, 16'd33, 1'b0);
        put(16'd24, 16'd34, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 16'd22, 16'd32}) begin fails++;
            $display("FAIL rm_second: en=%b r1=%0d r2=%0d want 1 22 32", o_en, o_r1, o_r2); end
        rst = 1'b1;
        #1;
        tests++; if ({o_en, o_r1, o_r2, o_done, o_err, s_ready, o_busy} !== 37'd0) begin fails++;
            $display("FAIL rm_async: en=%b r1=%0d r2=%0d done=%b err=%b ready=%b busy=%b want all 0", o_en, o_r1, o_r2, o_done, o_err, s_ready, o_busy); end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; #1;
        put(16'd41, 16'd51, 1'b0);
        put(16'd42, 16'd52, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 16'(41 + k), 16'(51 + k)}) begin fails++;
                $display("FAIL rm_fresh%0d: en=%b r1=%0d r2=%0d want 1 %0d %0d", k, o_en, o_r1, o_r2, 41 + k, 51 + k); end
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tests++; if ({o_en, o_r1, o_r2} !== {1'b1, 32'd0}) begin fails++;
                $display("FAIL rm_flush%0d: en=%b r1=%0d r2=%0d want 1 0 0", k, o_en, o_r1, o_r2); end
        end
        @(posedge clk); #1;
        tests++; if ({o_en, o_done, o_err} !== 3'b010) begin fails++;
            $display("FAIL rm_done: en/done/err=%b want 010", {o_en, o_done, o_err}); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_burst4();
        test_single();
        test_gaps();
        test_overflow();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
